// File: rtl/fir_tap_loader.sv
`default_nettype none
// ============================================================================
// Module   : fir_tap_loader
// Purpose  : Coefficient RAM plus loader that streams a complete tap set into
//            the serial tap-shift interface of an adjustable-tap FIR. h[0] is
//            shifted in first and h[NTAPS-1] last, so h[k] ends in stage k.
// Ports    : i_clk, i_reset    - clock, synchronous active-high reset
//            i_mem_wr/addr/data - random-address coefficient writes
//            i_start           - load request (level-sampled while idle)
//            o_busy            - load in progress (hold FIR i_ce off)
//            o_done            - one-cycle pulse at load completion
//            o_wr_drop         - one-cycle pulse after a rejected write
//            o_tap_wr, o_tap   - to FIR i_tap_wr / i_tap
// Revision : 1.0 - initial release
// ============================================================================
module fir_tap_loader #(
    parameter int NTAPS   = 128,
    parameter int TW      = 12,
    parameter int LGNTAPS = 7
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_mem_wr,
    input  logic [LGNTAPS-1:0] i_mem_addr,
    input  logic [TW-1:0]      i_mem_data,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_wr_drop,
    output logic               o_tap_wr,
    output logic [TW-1:0]      o_tap
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_load  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    // One extra bit so an address equal to NTAPS (power-of-two case) compares
    // correctly against the tap count.
    localparam logic [LGNTAPS:0]   c_ntaps     = (LGNTAPS+1)'(NTAPS);
    localparam logic [LGNTAPS-1:0] c_last_addr = LGNTAPS'(NTAPS - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [LGNTAPS-1:0] r_rd_addr;
    logic [TW-1:0]      r_mem [0:NTAPS-1];
    logic               r_tap_wr;
    logic [TW-1:0]      r_tap;
    logic               r_done;
    logic               r_wr_drop;

    logic               w_idle;
    logic               w_load;
    logic               w_addr_ok;
    logic               w_wr_accept;

    assign w_idle      = (r_state == c_st_idle);
    assign w_load      = (r_state == c_st_load);
    assign w_addr_ok   = ({1'b0, i_mem_addr} < c_ntaps);
    // Writes are only taken while idle so every load streams one consistent set.
    assign w_wr_accept = w_idle && i_mem_wr && w_addr_ok;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (i_start) begin
                    w_next_state = c_st_load;
                end
            end
            c_st_load: begin
                if (r_rd_addr == c_last_addr) begin
                    w_next_state = c_st_drain;
                end
            end
            c_st_drain: begin
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // Read address runs only in LOAD and sits at zero otherwise, so every
    // load begins at h[0].
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_addr <= '0;
        end else if (w_load) begin
            r_rd_addr <= r_rd_addr + LGNTAPS'(1);
        end else begin
            r_rd_addr <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Coefficient RAM (contents deliberately survive reset)
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_wr_accept) begin
            r_mem[i_mem_addr] <= i_mem_data;
        end
    end

    // ------------------------------------------------------------------
    // Output pipeline: read data and its valid are both one cycle behind
    // the LOAD-state read issue. o_tap only updates on a read, so it holds
    // the last tap between loads.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tap_wr  <= 1'b0;
            r_tap     <= '0;
            r_done    <= 1'b0;
            r_wr_drop <= 1'b0;
        end else begin
            r_tap_wr  <= w_load;
            r_done    <= (r_state == c_st_drain);
            r_wr_drop <= i_mem_wr && !w_wr_accept;
            if (w_load) begin
                r_tap <= r_mem[r_rd_addr];
            end
        end
    end

    assign o_busy    = !w_idle;
    assign o_done    = r_done;
    assign o_wr_drop = r_wr_drop;
    assign o_tap_wr  = r_tap_wr;
    assign o_tap     = r_tap;

endmodule
`default_nettype wire

// File: tb/tb_fir_tap_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_tap_loader
// Purpose  : Self-checking bench for fir_tap_loader. Two instances: an 8-tap
//            one for the main scenarios and a 6-tap one (3-bit address) for
//            out-of-range writes. Stimulus pushes expected taps, done pulses
//            and drop pulses (with their cycle numbers) into queues; a monitor
//            pops and compares whenever the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_tap_loader;

    localparam int N8 = 8;
    localparam int N6 = 6;
    localparam int TW = 12;

    typedef struct {
        int            c;
        logic [TW-1:0] v;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic          rst;
    logic          mem_wr8, start8, busy8, done8, drop8, tapwr8;
    logic [2:0]    addr8;
    logic [TW-1:0] data8, tap8;
    logic          mem_wr6, start6, busy6, done6, drop6, tapwr6;
    logic [2:0]    addr6;
    logic [TW-1:0] data6, tap6;

    fir_tap_loader #(.NTAPS(N8), .TW(TW), .LGNTAPS(3)) u_dut8 (
        .i_clk(clk), .i_reset(rst), .i_mem_wr(mem_wr8), .i_mem_addr(addr8),
        .i_mem_data(data8), .i_start(start8), .o_busy(busy8), .o_done(done8),
        .o_wr_drop(drop8), .o_tap_wr(tapwr8), .o_tap(tap8)
    );

    fir_tap_loader #(.NTAPS(N6), .TW(TW), .LGNTAPS(3)) u_dut6 (
        .i_clk(clk), .i_reset(rst), .i_mem_wr(mem_wr6), .i_mem_addr(addr6),
        .i_mem_data(data6), .i_start(start6), .o_busy(busy6), .o_done(done6),
        .o_wr_drop(drop6), .o_tap_wr(tapwr6), .o_tap(tap6)
    );

    exp_t          q8[$];
    exp_t          q6[$];
    int            qd8[$], qd6[$], qw8[$], qw6[$];
    exp_t          e8, e6;
    int            ev;
    logic [TW-1:0] m8 [N8];
    logic [TW-1:0] m6 [N6];
    logic [TW-1:0] fir [N8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected pulse at cycle %0d, nothing expected", name, cyc);
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard, sampling on the falling edge
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (tapwr8) begin
            for (int i = 0; i < N8 - 1; i++) fir[i] <= fir[i+1];
            fir[N8-1] <= tap8;
            if (q8.size() == 0) unexpected("tap8");
            else begin
                e8 = q8.pop_front();
                chk("tap8_cycle", cyc, e8.c);
                chk("tap8_value", int'(tap8), int'(e8.v));
            end
        end
        if (done8) begin
            if (qd8.size() == 0) unexpected("done8");
            else begin ev = qd8.pop_front(); chk("done8_cycle", cyc, ev); end
        end
        if (drop8) begin
            if (qw8.size() == 0) unexpected("drop8");
            else begin ev = qw8.pop_front(); chk("drop8_cycle", cyc, ev); end
        end
        if (tapwr6) begin
            if (q6.size() == 0) unexpected("tap6");
            else begin
                e6 = q6.pop_front();
                chk("tap6_cycle", cyc, e6.c);
                chk("tap6_value", int'(tap6), int'(e6.v));
            end
        end
        if (done6) begin
            if (qd6.size() == 0) unexpected("done6");
            else begin ev = qd6.pop_front(); chk("done6_cycle", cyc, ev); end
        end
        if (drop6) begin
            if (qw6.size() == 0) unexpected("drop6");
            else begin ev = qw6.pop_front(); chk("drop6_cycle", cyc, ev); end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (entered and left on a falling edge)
    // ------------------------------------------------------------------
    task automatic wr8(input int a, input logic [TW-1:0] d);
        mem_wr8 = 1'b1; addr8 = a[2:0]; data8 = d; m8[a] = d;
        @(negedge clk);
        mem_wr8 = 1'b0;
    endtask

    task automatic wr6(input int a, input logic [TW-1:0] d);
        mem_wr6 = 1'b1; addr6 = a[2:0]; data6 = d;
        if (a < N6) m6[a] = d;
        else qw6.push_back(cyc + 1);
        @(negedge clk);
        mem_wr6 = 1'b0;
    endtask

    // Start edge s = cyc+1; taps at s+1..s+N, done at s+N+1.
    task automatic push8(input int s);
        for (int k = 0; k < N8; k++) q8.push_back('{c: s + 1 + k, v: m8[k]});
        qd8.push_back(s + N8 + 1);
    endtask

    task automatic load8(input bit w, input int a, input logic [TW-1:0] d);
        if (w) begin mem_wr8 = 1'b1; addr8 = a[2:0]; data8 = d; m8[a] = d; end
        start8 = 1'b1;
        push8(cyc + 1);
        @(negedge clk);
        start8 = 1'b0; mem_wr8 = 1'b0;
        repeat (N8 + 1) @(negedge clk);
    endtask

    task automatic load6();
        int s;
        start6 = 1'b1;
        s = cyc + 1;
        for (int k = 0; k < N6; k++) q6.push_back('{c: s + 1 + k, v: m6[k]});
        qd6.push_back(s + N6 + 1);
        @(negedge clk);
        start6 = 1'b0;
        repeat (N6 + 1) @(negedge clk);
    endtask

    task automatic chk_outs8_zero(input string tag);
        chk({tag, "_busy"},   int'(busy8),  0);
        chk({tag, "_done"},   int'(done8),  0);
        chk({tag, "_drop"},   int'(drop8),  0);
        chk({tag, "_tap_wr"}, int'(tapwr8), 0);
        chk({tag, "_tap"},    int'(tap8),   0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int s;
        int lo;
        rst = 1'b1;
        mem_wr8 = 1'b0; addr8 = '0; data8 = '0; start8 = 1'b0;
        mem_wr6 = 1'b0; addr6 = '0; data6 = '0; start6 = 1'b0;
        repeat (2) @(negedge clk);
        chk_outs8_zero("reset8");
        chk("reset6_busy", int'(busy6), 0);
        chk("reset6_tap_wr", int'(tapwr6), 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic load: h[k] = k+1
        for (int k = 0; k < N8; k++) wr8(k, TW'(k + 1));
        load8(1'b0, 0, '0);
        for (int k = 0; k < N8; k++) chk($sformatf("fir_stage%0d", k), int'(fir[k]), k + 1);

        // Write while busy: dropped, h[3] keeps 4 in this and the next load
        start8 = 1'b1;
        s = cyc + 1;
        push8(s);
        @(negedge clk);
        start8 = 1'b0;
        mem_wr8 = 1'b1; addr8 = 3'd3; data8 = 12'h7FF;
        qw8.push_back(cyc + 1);
        @(negedge clk);
        mem_wr8 = 1'b0;
        chk("busy_drop_pulse", int'(drop8), 1);
        repeat (N8) @(negedge clk);
        chk("busy_model_h3", int'(m8[3]), 4);
        load8(1'b0, 0, '0);

        // Write and start in the same idle cycle: first tap is 0x800
        load8(1'b1, 0, 12'h800);

        // Continuous start for 30 cycles: loads at s, s+10, s+20
        start8 = 1'b1;
        s = cyc + 1;
        push8(s); push8(s + N8 + 2); push8(s + 2 * (N8 + 2));
        lo = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i < 29 && !busy8) lo++;
        end
        start8 = 1'b0;
        chk("busy_low_cycles", lo, 2);
        repeat (2) @(negedge clk);

        // Reset after the 4th tap write
        start8 = 1'b1;
        s = cyc + 1;
        for (int k = 0; k < 4; k++) q8.push_back('{c: s + 1 + k, v: m8[k]});
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_outs8_zero("midreset");
        rst = 1'b0;
        load8(1'b0, 0, '0);

        // Out-of-range addresses on the 6-tap instance
        for (int k = 0; k < N6; k++) wr6(k, TW'(k + 10));
        wr6(7, 12'h123);
        wr6(6, 12'h456);
        load6();
        chk("oor_model_h5", int'(m6[5]), 15);

        repeat (3) @(negedge clk);
        chk("q8_left", q8.size(), 0);
        chk("qd8_left", qd8.size(), 0);
        chk("qw8_left", qw8.size(), 0);
        chk("q6_left", q6.size(), 0);
        chk("qd6_left", qd6.size(), 0);
        chk("qw6_left", qw6.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
